// File: rtl/difftest_fpr_sync_ctrl_pkg.sv
// Shared constants, FSM state type and helpers for the difftest FP register
// snapshot controller.
package difftest_fpr_sync_ctrl_pkg;

    localparam int NUM_FPR = 32;
    localparam int XLEN    = 64;
    localparam int ADDR_W  = 5;
    localparam int CORE_W  = 8;
    localparam int SEQ_W   = 16;
    localparam int CNT_W   = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/difftest_fpr_shadow.sv
// Working copy of the architectural FP register file: two write ports (port 1
// wins on a same-index collision) and a flat read that already includes this
// cycle's writes.
module difftest_fpr_shadow #(
    parameter int NUM_FPR = difftest_fpr_sync_ctrl_pkg::NUM_FPR,
    parameter int XLEN    = difftest_fpr_sync_ctrl_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wen_0,
    input  logic [4:0]      waddr_0,
    input  logic [XLEN-1:0] wdata_0,
    input  logic            wen_1,
    input  logic [4:0]      waddr_1,
    input  logic [XLEN-1:0] wdata_1,
    output logic [XLEN-1:0] rd_data [NUM_FPR]
);
    import difftest_fpr_sync_ctrl_pkg::*;

    logic [XLEN-1:0] fpr_q [NUM_FPR];
    logic [XLEN-1:0] fpr_d [NUM_FPR];

    // Port 1 is applied last so it overrides port 0 on the same index.
    always_comb begin
        for (int i = 0; i < NUM_FPR; i++) begin
            fpr_d[i] = fpr_q[i];
            if (wen_0 && (waddr_0 == ADDR_W'(i))) begin
                fpr_d[i] = wdata_0;
            end
            if (wen_1 && (waddr_1 == ADDR_W'(i))) begin
                fpr_d[i] = wdata_1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_FPR; i++) begin
                fpr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_FPR; i++) begin
                fpr_q[i] <= fpr_d[i];
            end
        end
    end

    assign rd_data = fpr_d;

endmodule

// File: rtl/difftest_fpr_sync_ctrl.sv
// Freezes the architectural FP register state on commit requests and presents
// it to a difftest sink with a valid/ready handshake, merging overlapping requests.
module difftest_fpr_sync_ctrl #(
    parameter int NUM_FPR = difftest_fpr_sync_ctrl_pkg::NUM_FPR,
    parameter int XLEN    = difftest_fpr_sync_ctrl_pkg::XLEN
) (
    input  logic            io_clock,
    input  logic            io_reset_n,
    input  logic [7:0]      io_coreid,
    input  logic            io_enable,
    input  logic            io_wen_0,
    input  logic            io_wen_1,
    input  logic [4:0]      io_waddr_0,
    input  logic [4:0]      io_waddr_1,
    input  logic [XLEN-1:0] io_wdata_0,
    input  logic [XLEN-1:0] io_wdata_1,
    input  logic            io_commit_valid,
    output logic            io_snap_valid,
    input  logic            io_snap_ready,
    output logic [7:0]      io_snap_coreid,
    output logic [XLEN-1:0] io_snap_fpr_0,
    output logic [XLEN-1:0] io_snap_fpr_1,
    output logic [XLEN-1:0] io_snap_fpr_2,
    output logic [XLEN-1:0] io_snap_fpr_3,
    output logic [XLEN-1:0] io_snap_fpr_4,
    output logic [XLEN-1:0] io_snap_fpr_5,
    output logic [XLEN-1:0] io_snap_fpr_6,
    output logic [XLEN-1:0] io_snap_fpr_7,
    output logic [XLEN-1:0] io_snap_fpr_8,
    output logic [XLEN-1:0] io_snap_fpr_9,
    output logic [XLEN-1:0] io_snap_fpr_10,
    output logic [XLEN-1:0] io_snap_fpr_11,
    output logic [XLEN-1:0] io_snap_fpr_12,
    output logic [XLEN-1:0] io_snap_fpr_13,
    output logic [XLEN-1:0] io_snap_fpr_14,
    output logic [XLEN-1:0] io_snap_fpr_15,
    output logic [XLEN-1:0] io_snap_fpr_16,
    output logic [XLEN-1:0] io_snap_fpr_17,
    output logic [XLEN-1:0] io_snap_fpr_18,
    output logic [XLEN-1:0] io_snap_fpr_19,
    output logic [XLEN-1:0] io_snap_fpr_20,
    output logic [XLEN-1:0] io_snap_fpr_21,
    output logic [XLEN-1:0] io_snap_fpr_22,
    output logic [XLEN-1:0] io_snap_fpr_23,
    output logic [XLEN-1:0] io_snap_fpr_24,
    output logic [XLEN-1:0] io_snap_fpr_25,
    output logic [XLEN-1:0] io_snap_fpr_26,
    output logic [XLEN-1:0] io_snap_fpr_27,
    output logic [XLEN-1:0] io_snap_fpr_28,
    output logic [XLEN-1:0] io_snap_fpr_29,
    output logic [XLEN-1:0] io_snap_fpr_30,
    output logic [XLEN-1:0] io_snap_fpr_31,
    output logic [15:0]     io_snap_seq,
    output logic [15:0]     io_coalesce_cnt
);
    import difftest_fpr_sync_ctrl_pkg::*;

    localparam int NUM_OUT = 32;

    state_e            state_q, state_d;
    logic              pending_q, pending_d;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic [CNT_W-1:0]  coalesce_cnt_q, coalesce_cnt_d;
    logic [CORE_W-1:0] coreid_q, coreid_d;
    logic [XLEN-1:0]   snap_q [NUM_FPR];
    logic [XLEN-1:0]   snap_d [NUM_FPR];
    logic [XLEN-1:0]   shadow_rd [NUM_FPR];
    logic [XLEN-1:0]   snap_out [NUM_OUT];
    logic              accept;
    logic              capture;

    difftest_fpr_shadow #(
        .NUM_FPR (NUM_FPR),
        .XLEN    (XLEN)
    ) u_shadow (
        .clk     (io_clock),
        .rst_n   (io_reset_n),
        .wen_0   (io_wen_0),
        .waddr_0 (io_waddr_0),
        .wdata_0 (io_wdata_0),
        .wen_1   (io_wen_1),
        .waddr_1 (io_waddr_1),
        .wdata_1 (io_wdata_1),
        .rd_data (shadow_rd)
    );

    assign accept = io_commit_valid && io_enable;

    always_comb begin
        state_d        = state_q;
        pending_d      = pending_q;
        coalesce_cnt_d = coalesce_cnt_q;
        capture        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    capture = 1'b1;
                    state_d = VALID;
                end
            end
            VALID: begin
                if (io_snap_ready) begin
                    // Sink took the current snapshot; refill at once if anything is owed.
                    if (pending_q || accept) begin
                        capture   = 1'b1;
                        pending_d = 1'b0;
                        if (pending_q && accept) begin
                            coalesce_cnt_d = sat_inc(coalesce_cnt_q);
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end else if (accept) begin
                    pending_d = 1'b1;
                    if (pending_q) begin
                        coalesce_cnt_d = sat_inc(coalesce_cnt_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        seq_d    = capture ? seq_q + SEQ_W'(1) : seq_q;
        coreid_d = capture ? io_coreid : coreid_q;
        for (int i = 0; i < NUM_FPR; i++) begin
            snap_d[i] = capture ? shadow_rd[i] : snap_q[i];
        end
    end

    always_ff @(posedge io_clock or negedge io_reset_n) begin
        if (!io_reset_n) begin
            state_q        <= IDLE;
            pending_q      <= 1'b0;
            seq_q          <= '0;
            coalesce_cnt_q <= '0;
            coreid_q       <= '0;
            for (int i = 0; i < NUM_FPR; i++) begin
                snap_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            seq_q          <= seq_d;
            coalesce_cnt_q <= coalesce_cnt_d;
            coreid_q       <= coreid_d;
            for (int i = 0; i < NUM_FPR; i++) begin
                snap_q[i] <= snap_d[i];
            end
        end
    end

    // The output port set is fixed at 32; unused slots read as zero.
    for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_out
        if (gi < NUM_FPR) begin : g_used
            assign snap_out[gi] = snap_q[gi];
        end else begin : g_pad
            assign snap_out[gi] = '0;
        end
    end

    assign io_snap_valid   = (state_q == VALID);
    assign io_snap_coreid  = coreid_q;
    assign io_snap_seq     = seq_q;
    assign io_coalesce_cnt = coalesce_cnt_q;

    assign io_snap_fpr_0  = snap_out[0];
    assign io_snap_fpr_1  = snap_out[1];
    assign io_snap_fpr_2  = snap_out[2];
    assign io_snap_fpr_3  = snap_out[3];
    assign io_snap_fpr_4  = snap_out[4];
    assign io_snap_fpr_5  = snap_out[5];
    assign io_snap_fpr_6  = snap_out[6];
    assign io_snap_fpr_7  = snap_out[7];
    assign io_snap_fpr_8  = snap_out[8];
    assign io_snap_fpr_9  = snap_out[9];
    assign io_snap_fpr_10 = snap_out[10];
    assign io_snap_fpr_11 = snap_out[11];
    assign io_snap_fpr_12 = snap_out[12];
    assign io_snap_fpr_13 = snap_out[13];
    assign io_snap_fpr_14 = snap_out[14];
    assign io_snap_fpr_15 = snap_out[15];
    assign io_snap_fpr_16 = snap_out[16];
    assign io_snap_fpr_17 = snap_out[17];
    assign io_snap_fpr_18 = snap_out[18];
    assign io_snap_fpr_19 = snap_out[19];
    assign io_snap_fpr_20 = snap_out[20];
    assign io_snap_fpr_21 = snap_out[21];
    assign io_snap_fpr_22 = snap_out[22];
    assign io_snap_fpr_23 = snap_out[23];
    assign io_snap_fpr_24 = snap_out[24];
    assign io_snap_fpr_25 = snap_out[25];
    assign io_snap_fpr_26 = snap_out[26];
    assign io_snap_fpr_27 = snap_out[27];
    assign io_snap_fpr_28 = snap_out[28];
    assign io_snap_fpr_29 = snap_out[29];
    assign io_snap_fpr_30 = snap_out[30];
    assign io_snap_fpr_31 = snap_out[31];

endmodule

// File: doc/difftest_fpr_sync_ctrl.md
DIFFTEST_FPR_SYNC_CTRL -- requirements
Module: difftest_fpr_sync_ctrl

Interface
REQ-001 Parameters: NUM_FPR, default 32, number of FP arch registers; XLEN, default 64, register width.
REQ-002 Ports: io_clock  in  1  sole clock, rising edge.
REQ-003 Ports: io_reset_n  in  1  asynchronous reset, active-low.
REQ-004 Ports: io_coreid  in  8  hart id, registered into the snapshot.
REQ-005 Ports: io_enable  in  1  snapshot requests accepted only when 1.
REQ-006 Ports: io_wen_0, io_wen_1  in  1 each  architectural FP write enables from commit ports 0 and 1.
REQ-007 Ports: io_waddr_0, io_waddr_1  in  5 each  target register index.
REQ-008 Ports: io_wdata_0, io_wdata_1  in  XLEN each  write data.
REQ-009 Ports: io_commit_valid  in  1  one-cycle pulse requesting a snapshot of the architectural FP state.
REQ-010 Ports: io_snap_valid  out  1  snapshot available.
REQ-011 Ports: io_snap_ready  in  1  consumer (difftest FP state sink) accepts the snapshot.
REQ-012 Ports: io_snap_coreid  out  8  coreid captured with the snapshot.
REQ-013 Ports: io_snap_fpr_0 .. io_snap_fpr_31  out  XLEN each  frozen register values.
REQ-014 Ports: io_snap_seq  out  16  sequence number of the presented snapshot.
REQ-015 Ports: io_coalesce_cnt  out  16  count of requests merged into a later snapshot, saturating.

Function
REQ-016 The block SHALL keep a working shadow array of NUM_FPR x XLEN, updated every cycle by both write ports, independent of io_enable and FSM state.
REQ-017 When both ports write the same index in one cycle, port 1 SHALL win.
REQ-018 The FSM SHALL have two states: IDLE (io_snap_valid=0) and VALID (io_snap_valid=1), plus a 1-bit pending flag.
REQ-019 A capture SHALL copy the working array into the snapshot registers, bypassing same-cycle writes so that they are included, latch io_coreid, and increment seq with 16-bit wrap (0xFFFF -> 0x0000).
REQ-020 In IDLE, io_commit_valid=1 with io_enable=1 SHALL capture, and VALID SHALL be entered the next cycle (latency 1).
REQ-021 In VALID, snapshot outputs SHALL remain stable until the cycle in which io_snap_valid and io_snap_ready are both 1 (the handshake).
REQ-022 An accepted request in VALID without a handshake SHALL set pending; if pending is already 1, the request SHALL also increment io_coalesce_cnt, saturating at 0xFFFF.
REQ-023 At handshake, if pending=1 or an accepted request is present that cycle, the block SHALL capture, stay in VALID, and clear pending; otherwise it SHALL go to IDLE.
REQ-024 At handshake with pending=1 and a same-cycle accepted request, the block SHALL capture once and increment io_coalesce_cnt once.
REQ-025 Requests with io_enable=0 SHALL be dropped without being counted; clearing io_enable SHALL NOT cancel a presented snapshot or the pending flag.
REQ-026 io_snap_ready while in IDLE SHALL be ignored.

Reset
REQ-027 Assertion of io_reset_n=0 SHALL asynchronously force IDLE, pending=0, io_snap_valid=0, io_snap_seq=0, io_coalesce_cnt=0, io_snap_coreid=0, and all working and snapshot registers to 0.
REQ-028 A reset during VALID SHALL discard the snapshot with no handshake; the first capture after reset SHALL carry seq 1.

Structure
REQ-029 The shared package SHALL hold NUM_FPR, XLEN, the seq and counter widths, and the state enum {IDLE, VALID}.
REQ-030 The working array with two write ports and bypassed flat read SHALL be the sub-module difftest_fpr_shadow; the FSM, counters and snapshot registers SHALL live in the top module.

Verification
REQ-031 Scenario 1: write f3=0x3FF0000000000000 on port 0 in the same cycle as io_commit_valid, with ready held at 1 -> next cycle io_snap_valid=1, io_snap_fpr_3=0x3FF0000000000000, io_snap_seq=1; IDLE the following cycle.
REQ-032 Scenario 2: port 0 and port 1 both write f7 (0x11, 0x22) while a commit is requested -> io_snap_fpr_7=0x22.
REQ-033 Scenario 3: ready held at 0; three commits while VALID -> outputs stable; io_coalesce_cnt=2; raising ready -> the next snapshot has seq 2 and reflects the latest writes, then IDLE.
REQ-034 Scenario 4: seq forced to 0xFFFF, then one capture -> io_snap_seq=0x0000; io_coalesce_cnt held at 0xFFFF plus one more coalesce -> stays 0xFFFF.
REQ-035 Scenario 5: io_enable=0 with a commit pulse -> no io_snap_valid and counter unchanged; reset asserted mid-VALID -> all outputs 0 immediately (asynchronously); the next capture has seq 1.
